// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multicycle load/store core sharing one memory port for fetch and data
// Optional feature macro: CORE_MUL_EN (opcode 11 becomes MUL; otherwise opcode 11 is illegal).
module multicycle_core #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int NREGS  = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   input  logic [3:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data,
   output logic              halted,
   output logic              illegal
);

   localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_LD   = 4'd7;
   localparam logic [3:0] OP_ST   = 4'd8;
   localparam logic [3:0] OP_BEQZ = 4'd9;
   localparam logic [3:0] OP_JMP  = 4'd10;
`ifdef CORE_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'd11;
`endif
   localparam logic [3:0] OP_HALT = 4'd15;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_HALT
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic              started;
   logic [15:0]       ir;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] d_q;
   logic [DATA_W-1:0] res_q;
   logic [DATA_W-1:0] regs [NREGS];

   logic [3:0]        op;
   logic [RW-1:0]     rd;
   logic [RW-1:0]     rs1;
   logic [RW-1:0]     rs2;
   logic [3:0]        imm;
   logic [RW-1:0]     dbg_idx;
   logic              done;
   logic [DATA_W-1:0] alu_y;
   logic [DATA_W-1:0] ldst_sum;
   logic [15:0]       simm16;
   logic [15:0]       jmp16;
   logic              writes_rd;
   logic              is_ld;
   logic              is_st;
   logic              is_halt;
   logic              is_bad;
   logic              unused_bits;

   assign op       = ir[15:12];
   assign rd       = ir[8 +: RW];
   assign rs1      = ir[4 +: RW];
   assign rs2      = ir[0 +: RW];
   assign imm      = ir[3:0];
   assign dbg_idx  = dbg_sel[RW-1:0];
   assign done     = mem_req & mem_ready;
   assign ldst_sum = a_q + DATA_W'(imm);
   assign simm16   = {{12{imm[3]}}, imm};
   assign jmp16    = {8'h00, ir[7:0]};
   assign halted   = (state == S_HALT);

   // Register 0 is never written, so it keeps its reset value of zero.
   assign dbg_data = regs[dbg_idx];

   assign unused_bits = ^{dbg_sel, ir, simm16, jmp16, ldst_sum};

   // Opcode classification from the latched instruction.
   always_comb begin
      writes_rd = 1'b0;
      is_ld     = 1'b0;
      is_st     = 1'b0;
      is_halt   = 1'b0;
      is_bad    = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: writes_rd = 1'b1;
`ifdef CORE_MUL_EN
         OP_MUL:                  writes_rd = 1'b1;
`endif
         OP_LD:                   is_ld     = 1'b1;
         OP_ST:                   is_st     = 1'b1;
         OP_NOP, OP_BEQZ, OP_JMP: ;
         OP_HALT:                 is_halt   = 1'b1;
         default:                 is_bad    = 1'b1;
      endcase
   end

   // ALU result, wrapping modulo 2^DATA_W.
   always_comb begin
      alu_y = '0;
      case (op)
         OP_ADD:  alu_y = a_q + b_q;
         OP_SUB:  alu_y = a_q - b_q;
         OP_AND:  alu_y = a_q & b_q;
         OP_OR:   alu_y = a_q | b_q;
         OP_XOR:  alu_y = a_q ^ b_q;
         OP_ADDI: alu_y = a_q + DATA_W'(imm);
`ifdef CORE_MUL_EN
         OP_MUL:  alu_y = a_q * b_q;
`endif
         default: alu_y = '0;
      endcase
   end

   // State register; started keeps the first fetch off the bus until the first edge after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_FETCH;
         started <= 1'b0;
      end else begin
         state   <= state_nx;
         started <= 1'b1;
      end
   end

   // Next-state logic; memory states wait for a completed transfer.
   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH:     if (done) state_nx = S_DECODE;
         S_DECODE:    state_nx = S_EXECUTE;
         S_EXECUTE: begin
            if (is_halt)             state_nx = S_HALT;
            else if (is_ld || is_st) state_nx = S_MEMORY;
            else if (writes_rd)      state_nx = S_WRITEBACK;
            else                     state_nx = S_FETCH;
         end
         S_MEMORY:    if (done) state_nx = is_ld ? S_WRITEBACK : S_FETCH;
         S_WRITEBACK: state_nx = S_FETCH;
         S_HALT:      state_nx = S_HALT;
         default:     state_nx = S_FETCH;
      endcase
   end

   // Bus outputs are pure functions of registered state, so they hold steady during waits.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         S_FETCH: begin
            mem_req  = started;
            mem_addr = pc;
         end
         S_MEMORY: begin
            mem_req   = 1'b1;
            mem_we    = is_st;
            mem_addr  = addr_q;
            mem_wdata = is_st ? d_q : '0;
         end
         default: ;
      endcase
   end

   // Datapath: instruction latch, PC update, operand read, address/result capture, register write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc      <= '0;
         ir      <= '0;
         addr_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         res_q   <= '0;
         illegal <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (done) begin
                  ir <= mem_rdata[15:0];
                  pc <= pc + ADDR_W'(1);
               end
            end
            S_DECODE: begin
               a_q <= regs[rs1];
               b_q <= regs[rs2];
               d_q <= regs[rd];
            end
            S_EXECUTE: begin
               res_q  <= alu_y;
               addr_q <= ldst_sum[ADDR_W-1:0];
               if (is_bad) illegal <= 1'b1;
               if (op == OP_BEQZ && d_q == '0) pc <= pc + simm16[ADDR_W-1:0];
               if (op == OP_JMP) pc <= jmp16[ADDR_W-1:0];
            end
            S_MEMORY: begin
               if (done && is_ld) res_q <= mem_rdata;
            end
            S_WRITEBACK: begin
               if (rd != '0) regs[rd] <= res_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - table-driven and sequence checks for multicycle_core
module tb_multicycle_core;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int NREGS  = 8;
   localparam int NV     = 14;
   localparam logic [15:0] HLT = 16'hF000;

`ifdef CORE_MUL_EN
   localparam logic [15:0] MUL_EXP = 16'd12;
   localparam logic        MUL_ILL = 1'b0;
`else
   localparam logic [15:0] MUL_EXP = 16'd0;
   localparam logic        MUL_ILL = 1'b1;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ready = 1'b0;
   logic [3:0]        dbg_sel = 4'd0;
   logic [DATA_W-1:0] dbg_data;
   logic              halted;
   logic              illegal;

   typedef struct {
      logic [15:0] p0, p1, p2, p3;
      logic [3:0]  sel;
      logic [15:0] exp;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [7:0]  a;
      logic [15:0] d;
   } wr_t;

   logic [15:0] mem [256];
   wr_t         exp_wr [$];
   logic [7:0]  rd_log [$];
   vec_t        vecs [NV];
   int          total = 0;
   int          bad = 0;
   int          stall_seen = 0;
   int          force_wr_wait = 0;
   bit          rand_wait = 1'b0;
   bit          hold_all = 1'b0;

   multicycle_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data),
      .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int im);
      return {op[3:0], rd[3:0], rs[3:0], im[3:0]};
   endfunction

   function automatic vec_t mk(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                               input logic [15:0] p3, input logic [3:0] sel, input logic [15:0] exp,
                               input logic ill);
      vec_t v;
      v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
      v.sel = sel; v.exp = exp; v.ill = ill;
      return v;
   endfunction

   // Expected zero-wait cycle cost of one instruction.
   function automatic int cyc_of(input logic [15:0] ins);
      case (ins[15:12])
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: return 4;
         4'd7:  return 5;
         4'd8:  return 4;
`ifdef CORE_MUL_EN
         4'd11: return 4;
`endif
         default: return 3;
      endcase
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = HLT;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      hold_all = 1'b0;
      force_wr_wait = 0;
      stall_seen = 0;
      exp_wr.delete();
      rd_log.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Counts rising edges from the first visible request until halted rises.
   task automatic wait_halt(output int cycles, output bit ok);
      int n;
      n = 0;
      while (!mem_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      cycles = 0;
      while (!halted && cycles < 400) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      ok = halted;
   endtask

   // Memory model: decides ready at each falling edge, checks bus stability while waiting,
   // and scores writes against the queue of expected stores.
   initial begin : responder
      bit         waiting;
      int         wait_left;
      logic       snap_we;
      logic [7:0] snap_a;
      logic [15:0] snap_d;
      wr_t        w;
      waiting = 1'b0;
      wait_left = 0;
      forever begin
         @(negedge clk);
         if (!rst || !mem_req) begin
            mem_ready = 1'b0;
            waiting = 1'b0;
         end else begin
            if (!waiting) begin
               snap_we = mem_we;
               snap_a = mem_addr;
               snap_d = mem_wdata;
               if (mem_we && force_wr_wait > 0) begin
                  wait_left = force_wr_wait;
                  force_wr_wait = 0;
               end else begin
                  wait_left = rand_wait ? int'($urandom_range(0, 3)) : 0;
               end
            end else begin
               check("bus_stable_during_wait", {7'd0, mem_we, mem_addr, mem_wdata},
                     {7'd0, snap_we, snap_a, snap_d});
               if (mem_we) stall_seen++;
            end
            if (wait_left == 0 && !hold_all) begin
               mem_ready = 1'b1;
               waiting = 1'b0;
               if (mem_we) begin
                  check("write_expected", (exp_wr.size() > 0), 1);
                  if (exp_wr.size() > 0) begin
                     w = exp_wr.pop_front();
                     check("write_addr", mem_addr, w.a);
                     check("write_data", mem_wdata, w.d);
                  end
                  mem[mem_addr] = mem_wdata;
               end else begin
                  mem_rdata = mem[mem_addr];
                  rd_log.push_back(mem_addr);
               end
            end else begin
               mem_ready = 1'b0;
               if (wait_left > 0) wait_left--;
               waiting = 1'b1;
            end
         end
      end
   end

   initial begin : main
      int         cyc;
      bit         ok;
      bit         quiet;
      int         n;
      int         exp_cyc;
      bit         seen_halt;
      logic [15:0] pg [4];
      logic [7:0] exp_log [4];

      vecs[0]  = mk(enc(6,1,0,5),  enc(6,2,0,7),   enc(1,3,1,2),  HLT, 4'd3,  16'd12,   1'b0);
      vecs[1]  = mk(enc(6,2,0,1),  enc(2,1,0,2),   HLT,           HLT, 4'd1,  16'hFFFF, 1'b0);
      vecs[2]  = mk(enc(6,0,0,3),  HLT,            HLT,           HLT, 4'd0,  16'd0,    1'b0);
      vecs[3]  = mk(enc(6,1,0,12), enc(6,2,0,10),  enc(3,3,1,2),  HLT, 4'd3,  16'd8,    1'b0);
      vecs[4]  = mk(enc(6,1,0,12), enc(6,2,0,10),  enc(4,3,1,2),  HLT, 4'd3,  16'd14,   1'b0);
      vecs[5]  = mk(enc(6,1,0,12), enc(6,2,0,10),  enc(5,3,1,2),  HLT, 4'd3,  16'd6,    1'b0);
      vecs[6]  = mk(enc(6,1,0,15), enc(6,1,1,15),  enc(1,1,1,1),  HLT, 4'd1,  16'd60,   1'b0);
      vecs[7]  = mk(enc(6,1,0,3),  enc(6,2,0,4),   enc(11,3,1,2), HLT, 4'd3,  MUL_EXP,  MUL_ILL);
      vecs[8]  = mk(enc(6,3,0,9),  enc(13,3,1,2),  HLT,           HLT, 4'd3,  16'd9,    1'b1);
      vecs[9]  = mk(enc(6,1,0,15), enc(6,1,1,15),  enc(7,3,1,2),  HLT, 4'd3,  16'h1234, 1'b0);
      vecs[10] = mk(enc(6,1,0,5),  enc(6,2,0,7),   enc(1,3,1,2),  HLT, 4'd11, 16'd12,   1'b0);
      vecs[11] = mk(enc(6,1,0,15), enc(6,1,1,15),  enc(7,0,1,2),  HLT, 4'd0,  16'd0,    1'b0);
      vecs[12] = mk(enc(6,9,0,5),  HLT,            HLT,           HLT, 4'd1,  16'd5,    1'b0);
      vecs[13] = mk(16'h0000,      enc(6,1,0,1),   enc(12,0,0,0), HLT, 4'd1,  16'd1,    1'b1);

      // Reset state while rst is held low.
      dbg_sel = 4'd1;
      @(negedge clk);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_halted", halted, 0);
      check("rst_illegal", illegal, 0);
      check("rst_dbg", dbg_data, 0);

      // Table pass 0 zero-wait with cycle counts, pass 1 random waits.
      for (int pass = 0; pass < 2; pass++) begin
         rand_wait = (pass == 1);
         for (int i = 0; i < NV; i++) begin
            pg[0] = vecs[i].p0; pg[1] = vecs[i].p1; pg[2] = vecs[i].p2; pg[3] = vecs[i].p3;
            clear_mem();
            for (int k = 0; k < 4; k++) mem[k] = pg[k];
            mem[32] = 16'h1234;
            exp_cyc = 0;
            seen_halt = 1'b0;
            for (int k = 0; k < 4; k++) begin
               if (!seen_halt) begin
                  exp_cyc += cyc_of(pg[k]);
                  if (pg[k][15:12] == 4'hF) seen_halt = 1'b1;
               end
            end
            do_reset();
            wait_halt(cyc, ok);
            check($sformatf("p%0d_v%0d_halted", pass, i), ok, 1);
            if (!rand_wait) check($sformatf("p%0d_v%0d_cycles", pass, i), cyc, exp_cyc);
            quiet = 1'b1;
            repeat (3) begin
               @(negedge clk);
               if (mem_req) quiet = 1'b0;
            end
            check($sformatf("p%0d_v%0d_no_req_in_halt", pass, i), quiet, 1);
            dbg_sel = vecs[i].sel;
            #1;
            check($sformatf("p%0d_v%0d_dbg", pass, i), dbg_data, vecs[i].exp);
            check($sformatf("p%0d_v%0d_illegal", pass, i), illegal, vecs[i].ill);
         end
      end
      rand_wait = 1'b0;

      // Store then load through address 6 with the store held off for three cycles.
      clear_mem();
      mem[0]  = enc(10,0,1,0);
      mem[16] = enc(6,4,0,15);
      mem[17] = enc(6,4,4,15);
      mem[18] = enc(6,4,4,2);
      mem[19] = enc(7,1,4,0);
      mem[20] = enc(6,2,0,4);
      mem[21] = enc(8,1,2,2);
      mem[22] = enc(7,3,0,6);
      mem[23] = HLT;
      mem[32] = 16'h00A5;
      do_reset();
      exp_wr.push_back('{8'd6, 16'h00A5});
      force_wr_wait = 3;
      wait_halt(cyc, ok);
      check("st_ld_halted", ok, 1);
      check("st_queue_drained", exp_wr.size(), 0);
      check("st_wait_cycles", stall_seen, 3);
      check("st_mem6", mem[6], 16'h00A5);
      dbg_sel = 4'd3;
      #1;
      check("ld_r3", dbg_data, 16'h00A5);

      // BEQZ taken backwards, BEQZ not taken, JMP to the top address then wrap.
      for (int t = 0; t < 3; t++) begin
         clear_mem();
         if (t == 0) begin
            mem[0] = enc(10,0,0,5); mem[5] = enc(9,0,0,14);
            exp_log[0] = 8'h00; exp_log[1] = 8'h05; exp_log[2] = 8'h04; exp_log[3] = 8'h04;
         end else if (t == 1) begin
            mem[0] = enc(6,1,0,1); mem[1] = enc(9,1,0,14);
            exp_log[0] = 8'h00; exp_log[1] = 8'h01; exp_log[2] = 8'h02; exp_log[3] = 8'h02;
         end else begin
            mem[0] = enc(10,0,15,15); mem[255] = enc(6,1,1,1);
            exp_log[0] = 8'h00; exp_log[1] = 8'hFF; exp_log[2] = 8'h00; exp_log[3] = 8'hFF;
         end
         do_reset();
         n = 0;
         while (rd_log.size() < ((t == 2) ? 4 : 3) && n < 100) begin
            @(negedge clk);
            n++;
         end
         for (int k = 0; k < ((t == 2) ? 4 : 3); k++)
            check($sformatf("flow%0d_fetch%0d", t, k),
                  (k < rd_log.size()) ? {24'd0, rd_log[k]} : 32'hFFFF_FFFF, {24'd0, exp_log[k]});
      end

      // Reset asserted in the middle of a stalled fetch.
      clear_mem();
      mem[0] = enc(13,0,0,0);
      mem[1] = 16'h0000;
      do_reset();
      n = 0;
      while (rd_log.size() < 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      hold_all = 1'b1;
      n = 0;
      while (!(mem_req && mem_addr == 8'd2) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("pre_rst_stalled_at_2", {mem_req, mem_addr}, {1'b1, 8'd2});
      check("pre_rst_illegal", illegal, 1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_req", mem_req, 0);
      check("mid_rst_addr", mem_addr, 0);
      check("mid_rst_we_wdata", {mem_we, mem_wdata}, 0);
      check("mid_rst_halted", halted, 0);
      check("mid_rst_illegal", illegal, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      hold_all = 1'b0;
      #1;
      check("release_req_before_edge", mem_req, 0);
      @(posedge clk);
      #1;
      check("release_first_fetch", {mem_req, mem_addr}, {1'b1, 8'd0});
      wait_halt(cyc, ok);
      check("release_halted", ok, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
